// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and one-outstanding-request instruction fetch sequencer
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  input  logic        instr_ready,
  input  logic [31:0] next_pc,
  output logic        fetch_fault,
  output logic [31:0] retire_count
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc;
  logic retire, misaligned;
  assign retire = state == HOLD && instr_ready;
  assign misaligned = ALIGN_CHECK && next_pc[1:0] != 2'b00;
  assign imem_req_valid = state == REQ && !reset;
  assign imem_req_addr = pc;
  assign instr_valid = state == HOLD && !reset;
  assign instr_addr = pc;
  always_comb begin
    state_nx = FAULT;
    state_nx = state == REQ  ? (imem_req_ready ? WAIT : REQ) :
               state == WAIT ? (imem_resp_valid ? HOLD : WAIT) :
               state == HOLD ? (instr_ready ? (misaligned ? FAULT : REQ) : HOLD) : FAULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      instr_data <= 32'h0;
      fetch_fault <= 1'b0;
      retire_count <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == WAIT && imem_resp_valid) instr_data <= imem_resp_data;
      if (retire) begin
        retire_count <= retire_count + 32'd1;
        pc <= misaligned ? next_pc : {next_pc[31:2], 2'b00};
        fetch_fault <= fetch_fault | misaligned;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: two DUTs (align check on/off) sharing stimulus, checked every cycle against a transaction-level model
module tb_instr_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, imem_req_ready = 1'b0, imem_resp_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] imem_resp_data = 32'h0, next_pc = 32'h0;
  logic [1:0] rqv, iv, ff;
  logic [1:0][31:0] ra, idat, ia, rc;
  typedef struct {
    logic [31:0] pc, data, cnt;
    bit fault, asked, have;
  } mdl_t;
  mdl_t m[2];
  int n_chk = 0, n_fail = 0, cyc = 0, rsp = 0;
  bit en = 1'b0;
  logic [31:0] acc0_q[$], acc1_q[$], rqa_q[$], id_q[$], ia_q[$];
  int iv_q[$];
  always #5 clk = ~clk;
  instr_fetch_unit #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b1)) u0 (
    .clk(clk), .reset(reset), .imem_req_valid(rqv[0]), .imem_req_addr(ra[0]),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(iv[0]), .instr_data(idat[0]), .instr_addr(ia[0]), .instr_ready(instr_ready),
    .next_pc(next_pc), .fetch_fault(ff[0]), .retire_count(rc[0]));
  instr_fetch_unit #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b0)) u1 (
    .clk(clk), .reset(reset), .imem_req_valid(rqv[1]), .imem_req_addr(ra[1]),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(iv[1]), .instr_data(idat[1]), .instr_addr(ia[1]), .instr_ready(instr_ready),
    .next_pc(next_pc), .fetch_fault(ff[1]), .retire_count(rc[1]));
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endfunction
  function automatic void clr();
    acc0_q.delete(); acc1_q.delete(); rqa_q.delete(); iv_q.delete(); id_q.delete(); ia_q.delete();
  endfunction
  task automatic step(input bit r, input bit rr, input bit rv, input logic [31:0] rd, input bit ir, input logic [31:0] np);
    reset = r; imem_req_ready = rr; imem_resp_valid = rv; imem_resp_data = rd; instr_ready = ir; next_pc = np;
    #1;
    if (en) for (int k = 0; k < 2; k++) begin
      chk($sformatf("req_valid%0d", k), 32'(rqv[k]), 32'(!m[k].fault && !m[k].asked && !m[k].have && !r));
      chk($sformatf("req_addr%0d", k), ra[k], m[k].pc);
      chk($sformatf("instr_valid%0d", k), 32'(iv[k]), 32'(m[k].have && !r));
      chk($sformatf("instr_data%0d", k), idat[k], m[k].data);
      chk($sformatf("instr_addr%0d", k), ia[k], m[k].pc);
      chk($sformatf("fetch_fault%0d", k), 32'(ff[k]), 32'(m[k].fault));
      chk($sformatf("retire_count%0d", k), rc[k], m[k].cnt);
    end
    if (rqv[0]) rqa_q.push_back(ra[0]);
    if (rqv[0] && rr) acc0_q.push_back(ra[0]);
    if (rqv[1] && rr) acc1_q.push_back(ra[1]);
    if (iv[0]) begin
      iv_q.push_back(cyc); id_q.push_back(idat[0]); ia_q.push_back(ia[0]);
    end
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m[k].pc = 32'h0; m[k].data = 32'h0; m[k].cnt = 32'h0;
        m[k].fault = 1'b0; m[k].asked = 1'b0; m[k].have = 1'b0;
      end else if (m[k].fault) begin
      end else if (m[k].have) begin
        if (ir) begin
          m[k].cnt++;
          m[k].have = 1'b0;
          if (k == 0 && np[1:0] != 2'b00) begin
            m[k].pc = np; m[k].fault = 1'b1;
          end else m[k].pc = np & 32'hFFFF_FFFC;
        end
      end else if (m[k].asked) begin
        if (rv) begin
          m[k].data = rd; m[k].asked = 1'b0; m[k].have = 1'b1;
        end
      end else if (rr) m[k].asked = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    en = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_req_valid", 32'(rqv[0]), 0);
    chk("rst_instr_valid", 32'(iv[0]), 0);
    chk("rst_instr_data", idat[0], 0);
    chk("rst_fault", 32'(ff[0]), 0);
    chk("rst_retire", rc[0], 0);
    chk("rst_pc", ra[0], 0);
    clr();
    for (int i = 0; i < 9; i++) step(0, 1, 1, 32'h13 + 32'(i), 1, m[0].pc + 32'd4);
    chk("zw_n_acc", 32'(acc0_q.size()), 3);
    chk("zw_addr0", acc0_q[0], 32'h0);
    chk("zw_addr1", acc0_q[1], 32'h4);
    chk("zw_addr2", acc0_q[2], 32'h8);
    chk("zw_n_iv", 32'(iv_q.size()), 3);
    chk("zw_gap01", 32'(iv_q[1] - iv_q[0]), 3);
    chk("zw_gap12", 32'(iv_q[2] - iv_q[1]), 3);
    chk("zw_data0", id_q[0], 32'h14);
    chk("zw_retire", rc[0], 3);
    step(1, 0, 0, 0, 0, 0);
    clr();
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    rsp = cyc;
    step(0, 0, 1, 32'h0000_0013, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    chk("stall_n_req", 32'(rqa_q.size()), 5);
    foreach (rqa_q[i]) chk("stall_req_addr", rqa_q[i], 32'h0);
    chk("stall_n_acc", 32'(acc0_q.size()), 1);
    chk("resp_to_valid", 32'(iv_q[0]), 32'(rsp + 1));
    chk("hold_n_iv", 32'(iv_q.size()), 6);
    foreach (id_q[i]) chk("hold_data", id_q[i], 32'h0000_0013);
    foreach (ia_q[i]) chk("hold_addr", ia_q[i], 32'h0);
    step(0, 0, 0, 0, 1, 32'h100);
    clr();
    step(0, 1, 0, 0, 0, 0);
    chk("branch_n_acc", 32'(acc0_q.size()), 1);
    chk("branch_addr", acc0_q[0], 32'h100);
    step(0, 0, 1, 32'h0bad_c0de, 0, 0);
    step(0, 0, 0, 0, 1, 32'h102);
    clr();
    repeat (4) step(0, 1, 1, 32'h1234_5678, 1, 32'h200);
    chk("fault_flag", 32'(ff[0]), 1);
    chk("fault_addr", ia[0], 32'h102);
    chk("fault_no_valid", 32'(iv[0]), 0);
    chk("fault_no_req", 32'(rqa_q.size()), 0);
    chk("noalign_addr", acc1_q[0], 32'h100);
    chk("noalign_next", acc1_q[1], 32'h200);
    chk("noalign_fault", 32'(ff[1]), 0);
    step(1, 0, 0, 0, 0, 0);
    clr();
    step(0, 1, 0, 0, 0, 0);
    chk("fault_cleared", 32'(ff[0]), 0);
    chk("restart_addr", acc0_q[0], 32'h0);
    step(0, 0, 1, 32'h13, 0, 0);
    step(0, 0, 0, 0, 1, 32'h103);
    clr();
    step(0, 1, 0, 0, 0, 0);
    chk("noalign103_addr", acc1_q[0], 32'h100);
    chk("noalign103_fault", 32'(ff[1]), 0);
    chk("align103_addr", ia[0], 32'h103);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    clr();
    step(0, 0, 1, 32'h0000_dead, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("late_resp_no_valid", 32'(iv_q.size()), 0);
    chk("late_resp_n_req", 32'(rqa_q.size()), 4);
    chk("late_resp_req_addr", rqa_q[0], 32'h0);
    chk("late_resp_retire", rc[0], 0);
    chk("late_resp_data", idat[0], 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(63) == 0), 1'($urandom_range(1)), 1'($urandom_range(2) == 0), $urandom,
           1'($urandom_range(1)), ($urandom_range(5) == 0) ? $urandom : m[0].pc + 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
